// File: rtl/cache_nway.sv
// cache_nway: blocking set-associative write-back cache with tree-PLRU replacement and an uncached bypass path.
module cache_nway #(
  parameter int WAYS  = 2,
  parameter int IDX_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic                op,
  input  logic                uncached,
  input  logic [IDX_W-1:0]    index,
  input  logic [27-IDX_W:0]   tag,
  input  logic [3:0]          offset,
  input  logic [3:0]          wstrb,
  input  logic [31:0]         wdata,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [31:0]         rdata,
  output logic                rd_req,
  output logic [2:0]          rd_type,
  output logic [31:0]         rd_addr,
  input  logic                rd_rdy,
  input  logic                ret_valid,
  input  logic                ret_last,
  input  logic [31:0]         ret_data,
  output logic                wr_req,
  output logic [2:0]          wr_type,
  output logic [31:0]         wr_addr,
  output logic [3:0]          wr_strb,
  output logic [127:0]        wr_data,
  input  logic                wr_rdy
);
  localparam int SETS  = 1 << IDX_W;
  localparam int TAG_W = 28 - IDX_W;
  localparam int WW    = (WAYS > 2) ? 2 : 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REPLACE, REFILL, UC_RD, UC_WR} state_t;
  state_t state_q, state_d;
  logic op_q, op_d, uc_q, uc_d, sent_q, sent_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [3:0] off_q, off_d, wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0] cnt_q, cnt_d;
  logic [WW-1:0] victim_q, victim_d;
  logic [31:0] data_ram [WAYS][SETS][4];
  logic [TAG_W-1:0] tag_ram [WAYS][SETS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [2:0] plru_q [SETS];
  logic hit, inv_found, dwe, fill_we, dirty_set, plru_we;
  logic [WW-1:0] hit_way, inv_way, pick, dway, plru_way;
  logic [1:0] dword, pv2, w2;
  logic [31:0] dval, hit_word;
  logic [2:0] plru_cur, plru_nx;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction
  // Lowest-numbered matching/invalid way wins because the loop walks downward.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    inv_found = 1'b0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[index_q][i]) begin
        inv_found = 1'b1;
        inv_way = WW'(i);
      end
      if (valid_q[index_q][i] && tag_ram[i][index_q] == tag_q) begin
        hit = 1'b1;
        hit_way = WW'(i);
      end
    end
  end
  // PLRU bit 0 is the root (1 = victimise the upper half); bits 1/2 choose within the lower/upper pair.
  assign plru_cur = plru_q[index_q];
  assign hit_word = data_ram[hit_way][index_q][off_q[3:2]];
  assign pv2 = (WAYS == 4) ? {plru_cur[0], plru_cur[0] ? plru_cur[2] : plru_cur[1]} : {1'b0, plru_cur[0]};
  assign pick = inv_found ? inv_way : pv2[WW-1:0];
  assign w2 = 2'(plru_way);
  assign plru_nx = (WAYS == 4) ? (w2[1] ? {~w2[0], plru_cur[1], 1'b0} : {plru_cur[2], ~w2[0], 1'b1})
                               : {plru_cur[2:1], ~w2[0]};
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    uc_d = uc_q;
    index_d = index_q;
    tag_d = tag_q;
    off_d = off_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    sent_d = sent_q;
    victim_d = victim_q;
    addr_ok = state_q == IDLE;
    data_ok = 1'b0;
    rdata = '0;
    rd_req = 1'b0;
    rd_type = '0;
    rd_addr = '0;
    wr_req = 1'b0;
    wr_type = '0;
    wr_addr = '0;
    wr_strb = '0;
    wr_data = '0;
    dwe = 1'b0;
    dway = victim_q;
    dword = cnt_q;
    dval = ret_data;
    fill_we = 1'b0;
    dirty_set = 1'b0;
    plru_we = 1'b0;
    plru_way = victim_q;
    case (state_q)
      IDLE: if (valid) begin
        {op_d, uc_d, index_d, tag_d, off_d, wstrb_d, wdata_d} = {op, uncached, index, tag, offset, wstrb, wdata};
        state_d = LOOKUP;
      end
      LOOKUP: if (uc_q) begin
        state_d = op_q ? UC_WR : UC_RD;
        sent_d = 1'b0;
      end else if (hit) begin
        data_ok = 1'b1;
        rdata = op_q ? '0 : hit_word;
        plru_we = 1'b1;
        plru_way = hit_way;
        dwe = op_q;
        dirty_set = op_q;
        dway = hit_way;
        dword = off_q[3:2];
        dval = merge(hit_word, wdata_q, wstrb_q);
        state_d = IDLE;
      end else begin
        victim_d = pick;
        state_d = (valid_q[index_q][pick] && dirty_q[index_q][pick]) ? MISS : REPLACE;
      end
      MISS: begin
        wr_req = 1'b1;
        wr_type = 3'b100;
        wr_addr = {tag_ram[victim_q][index_q], index_q, 4'h0};
        wr_strb = 4'hf;
        wr_data = {data_ram[victim_q][index_q][3], data_ram[victim_q][index_q][2],
                   data_ram[victim_q][index_q][1], data_ram[victim_q][index_q][0]};
        state_d = wr_rdy ? REPLACE : MISS;
      end
      REPLACE: begin
        rd_req = 1'b1;
        rd_type = 3'b100;
        rd_addr = {tag_q, index_q, 4'h0};
        cnt_d = '0;
        state_d = rd_rdy ? REFILL : REPLACE;
      end
      REFILL: if (ret_valid) begin
        dwe = 1'b1;
        dval = (op_q && cnt_q == off_q[3:2]) ? merge(ret_data, wdata_q, wstrb_q) : ret_data;
        cnt_d = cnt_q + 2'd1;
        data_ok = op_q ? ret_last : cnt_q == off_q[3:2];
        rdata = (!op_q && cnt_q == off_q[3:2]) ? ret_data : '0;
        fill_we = ret_last;
        plru_we = ret_last;
        state_d = ret_last ? IDLE : REFILL;
      end
      UC_RD: begin
        rd_req = !sent_q;
        rd_type = 3'b010;
        rd_addr = {tag_q, index_q, off_q};
        sent_d = sent_q | rd_rdy;
        data_ok = sent_q && ret_valid;
        rdata = (sent_q && ret_valid) ? ret_data : '0;
        state_d = (sent_q && ret_valid) ? IDLE : UC_RD;
      end
      UC_WR: begin
        wr_req = 1'b1;
        wr_type = 3'b010;
        wr_addr = {tag_q, index_q, off_q};
        wr_strb = wstrb_q;
        wr_data = {96'h0, wdata_q};
        data_ok = wr_rdy;
        state_d = wr_rdy ? IDLE : UC_WR;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
      rdata = '0;
      rd_req = 1'b0;
      wr_req = 1'b0;
      dwe = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sent_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sent_q <= sent_d;
    end
    {op_q, uc_q, index_q, tag_q, off_q, wstrb_q, wdata_q, victim_q} <=
      {op_d, uc_d, index_d, tag_d, off_d, wstrb_d, wdata_d, victim_d};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s] <= '0;
      end
    end else begin
      if (fill_we) begin
        valid_q[index_q][victim_q] <= 1'b1;
        dirty_q[index_q][victim_q] <= op_q;
      end
      if (dirty_set) dirty_q[index_q][hit_way] <= 1'b1;
      if (plru_we) plru_q[index_q] <= plru_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (dwe) data_ram[dway][index_q][dword] <= dval;
    if (fill_we && !reset) tag_ram[victim_q][index_q] <= tag_q;
  end
endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway: directed checks of cache_nway (2 ways, 256 sets) against hand-computed bus and data values.
module tb_cache_nway;
  logic clk = 1'b0;
  logic reset, valid, op, uncached;
  logic [7:0] index;
  logic [19:0] tag;
  logic [3:0] offset, wstrb;
  logic [31:0] wdata;
  logic addr_ok, data_ok;
  logic [31:0] rdata;
  logic rd_req, rd_rdy, ret_valid, ret_last, wr_req, wr_rdy;
  logic [2:0] rd_type, wr_type;
  logic [31:0] rd_addr, ret_data, wr_addr;
  logic [3:0] wr_strb;
  logic [127:0] wr_data;
  int checks = 0;
  int errors = 0;

  cache_nway #(.WAYS(2), .IDX_W(8)) dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .uncached(uncached),
    .index(index), .tag(tag), .offset(offset), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_strb(wr_strb),
    .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic o, input logic u, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    valid = 1'b1;
    op = o;
    uncached = u;
    tag = a[31:12];
    index = a[11:4];
    offset = a[3:0];
    wstrb = be;
    wdata = d;
    #1;
    check("addr_ok_issue", 128'(addr_ok), 128'(1));
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_rd(input logic [31:0] a, input logic [2:0] t);
    int n = 0;
    #1;
    while (!rd_req && n < 10) begin
      tick();
      #1;
      n++;
    end
    check("rd_req", 128'(rd_req), 128'(1));
    check("rd_addr", 128'(rd_addr), 128'(a));
    check("rd_type", 128'(rd_type), 128'(t));
    check("rd_wr_exclusive", 128'(wr_req), 128'(0));
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
  endtask

  task automatic refill(input logic [127:0] line, input int ok_beat, input logic [31:0] exp);
    for (int i = 0; i < 4; i++) begin
      ret_valid = 1'b1;
      ret_data = line[32*i +: 32];
      ret_last = (i == 3);
      #1;
      check("refill_data_ok", 128'(data_ok), 128'(i == ok_beat));
      check("refill_rdata", 128'(rdata), 128'((i == ok_beat) ? exp : 32'h0));
      tick();
    end
    ret_valid = 1'b0;
    ret_last = 1'b0;
  endtask

  task automatic uc_load(input logic [31:0] a, input logic [31:0] d);
    issue(1'b0, 1'b1, a, 4'h0, 32'h0);
    #1;
    check("uc_lookup_data_ok", 128'(data_ok), 128'(0));
    tick();
    #1;
    check("uc_rd_req", 128'(rd_req), 128'(1));
    check("uc_rd_type", 128'(rd_type), 128'(3'b010));
    check("uc_rd_addr", 128'(rd_addr), 128'(a));
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    #1;
    check("uc_rd_req_dropped", 128'(rd_req), 128'(0));
    tick();
    ret_valid = 1'b1;
    ret_last = 1'b1;
    ret_data = d;
    #1;
    check("uc_data_ok", 128'(data_ok), 128'(1));
    check("uc_rdata", 128'(rdata), 128'(d));
    tick();
    ret_valid = 1'b0;
    ret_last = 1'b0;
  endtask

  initial begin
    {reset, valid, op, uncached, index, tag, offset, wstrb, wdata} = '0;
    {rd_rdy, ret_valid, ret_last, ret_data, wr_rdy} = '0;
    reset = 1'b1;
    repeat (3) tick();
    #1;
    check("rst_addr_ok", 128'(addr_ok), 128'(0));
    check("rst_data_ok", 128'(data_ok), 128'(0));
    check("rst_rd_req", 128'(rd_req), 128'(0));
    check("rst_wr_req", 128'(wr_req), 128'(0));
    check("rst_rdata", 128'(rdata), 128'(0));
    tick();
    reset = 1'b0;
    #1;
    check("addr_ok_after_reset", 128'(addr_ok), 128'(1));
    // Load miss, refill, then hit of the same word
    issue(1'b0, 1'b0, 32'h0000_1004, 4'h0, 32'h0);
    #1;
    check("miss_lookup_data_ok", 128'(data_ok), 128'(0));
    tick();
    #1;
    check("rd_req_held", 128'(rd_req), 128'(1));
    tick();
    wait_rd(32'h0000_1000, 3'b100);
    refill(128'h44444444_33333333_22222222_11111111, 1, 32'h22222222);
    issue(1'b0, 1'b0, 32'h0000_1004, 4'h0, 32'h0);
    #1;
    check("hit_data_ok", 128'(data_ok), 128'(1));
    check("hit_rdata", 128'(rdata), 128'(32'h22222222));
    check("hit_no_rd", 128'(rd_req), 128'(0));
    tick();
    // Store hit merges bytes
    issue(1'b1, 1'b0, 32'h0000_1004, 4'b0011, 32'hAAAABBBB);
    #1;
    check("st_hit_data_ok", 128'(data_ok), 128'(1));
    check("st_hit_no_wr", 128'(wr_req), 128'(0));
    check("st_hit_no_rd", 128'(rd_req), 128'(0));
    tick();
    issue(1'b0, 1'b0, 32'h0000_1004, 4'h0, 32'h0);
    #1;
    check("st_merge_rdata", 128'(rdata), 128'(32'h2222BBBB));
    tick();
    issue(1'b0, 1'b0, 32'h0000_1008, 4'h0, 32'h0);
    #1;
    check("word2_rdata", 128'(rdata), 128'(32'h33333333));
    tick();
    // Second way, dirty it, touch way 0, then force eviction of the dirty way 1
    issue(1'b0, 1'b0, 32'h0000_2000, 4'h0, 32'h0);
    #1;
    check("tag2_miss", 128'(data_ok), 128'(0));
    check("tag2_no_wr", 128'(wr_req), 128'(0));
    tick();
    wait_rd(32'h0000_2000, 3'b100);
    refill(128'h88888888_77777777_66666666_55555555, 0, 32'h55555555);
    issue(1'b1, 1'b0, 32'h0000_2000, 4'hf, 32'hDEADBEEF);
    #1;
    check("tag2_st_hit", 128'(data_ok), 128'(1));
    tick();
    issue(1'b0, 1'b0, 32'h0000_1000, 4'h0, 32'h0);
    #1;
    check("tag1_rdata", 128'(rdata), 128'(32'h11111111));
    tick();
    issue(1'b0, 1'b0, 32'h0000_3000, 4'h0, 32'h0);
    #1;
    check("tag3_miss", 128'(data_ok), 128'(0));
    tick();
    #1;
    check("wb_wr_req", 128'(wr_req), 128'(1));
    check("wb_wr_addr", 128'(wr_addr), 128'(32'h0000_2000));
    check("wb_wr_type", 128'(wr_type), 128'(3'b100));
    check("wb_wr_strb", 128'(wr_strb), 128'(4'hf));
    check("wb_wr_data", wr_data, 128'h88888888_77777777_66666666_DEADBEEF);
    check("wb_no_rd", 128'(rd_req), 128'(0));
    tick();
    #1;
    check("wb_held", 128'(wr_req), 128'(1));
    wr_rdy = 1'b1;
    tick();
    wr_rdy = 1'b0;
    wait_rd(32'h0000_3000, 3'b100);
    refill(128'hCCCCCCCC_BBBBBBBB_AAAAAAAA_99999999, 0, 32'h99999999);
    issue(1'b0, 1'b0, 32'h0000_1000, 4'h0, 32'h0);
    #1;
    check("tag1_still_hit", 128'(data_ok), 128'(1));
    check("tag1_still_rdata", 128'(rdata), 128'(32'h11111111));
    tick();
    issue(1'b0, 1'b0, 32'h0000_300C, 4'h0, 32'h0);
    #1;
    check("tag3_hit_rdata", 128'(rdata), 128'(32'hCCCCCCCC));
    tick();
    // Uncached load twice: both must go to the bridge
    uc_load(32'hBFAF_8000, 32'h0000_0005);
    uc_load(32'hBFAF_8000, 32'h0000_0006);
    // Uncached store
    issue(1'b1, 1'b1, 32'hBFAF_8004, 4'b1000, 32'h12345678);
    tick();
    #1;
    check("ucw_wr_req", 128'(wr_req), 128'(1));
    check("ucw_wr_type", 128'(wr_type), 128'(3'b010));
    check("ucw_wr_addr", 128'(wr_addr), 128'(32'hBFAF_8004));
    check("ucw_wr_strb", 128'(wr_strb), 128'(4'b1000));
    check("ucw_wr_data", wr_data, 128'h12345678);
    check("ucw_no_ok_yet", 128'(data_ok), 128'(0));
    wr_rdy = 1'b1;
    #1;
    check("ucw_data_ok", 128'(data_ok), 128'(1));
    tick();
    wr_rdy = 1'b0;
    #1;
    check("ucw_idle", 128'(addr_ok), 128'(1));
    // Reset in the middle of a refill abandons the line
    issue(1'b0, 1'b0, 32'h0000_501C, 4'h0, 32'h0);
    tick();
    wait_rd(32'h0000_5010, 3'b100);
    for (int i = 0; i < 2; i++) begin
      ret_valid = 1'b1;
      ret_data = 32'h5000_0000 + i;
      tick();
    end
    ret_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_addr_ok", 128'(addr_ok), 128'(0));
    check("midrst_rd_req", 128'(rd_req), 128'(0));
    tick();
    reset = 1'b0;
    #1;
    check("postrst_rd_req", 128'(rd_req), 128'(0));
    check("postrst_addr_ok", 128'(addr_ok), 128'(1));
    issue(1'b0, 1'b0, 32'h0000_501C, 4'h0, 32'h0);
    #1;
    check("aborted_line_miss", 128'(data_ok), 128'(0));
    tick();
    wait_rd(32'h0000_5010, 3'b100);
    refill(128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1, 3, 32'hD4D4D4D4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
